// File: rtl/bus_hold_responder_if.sv
// Processor/DMA handshake bundle for the bus-hold responder: hold request/acknowledge
// plus the single-beat processor access request and its completion pulse.
interface bus_hold_responder_if;
   logic       hld;
   logic       hlda;
   logic       cpu_req;
   logic       cpu_rw;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic [7:0] cpu_rdata;
   logic       cpu_ready;

   modport master (
      output hld, cpu_req, cpu_rw, cpu_addr, cpu_wdata,
      input  hlda, cpu_rdata, cpu_ready
   );

   modport slave (
      input  hld, cpu_req, cpu_rw, cpu_addr, cpu_wdata,
      output hlda, cpu_rdata, cpu_ready
   );
endinterface

// File: rtl/bus_hold_responder.sv
// Owns the shared bus for the processor; access = 1 cycle + 1-cycle ready pulse, hold grant 2 cycles after hld.
// Processor requests stall (never drop) while the bus is floated; a post-release guard gives the CPU priority.
module bus_hold_responder #(
   parameter int MIN_CPU_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   bus_hold_responder_if.slave  bus,
   output wire  [7:0]           addressbus,
   output wire                  control,
   inout  wire  [7:0]           databus
);

   localparam int GW = (MIN_CPU_CYCLES < 1) ? 1 : $clog2(MIN_CPU_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCESS,
      S_FLOAT,
      S_HOLD,
      S_RELEASE
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   guard_q, guard_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            ready_q, ready_d;
   logic            drive_bus;
   logic            in_access;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         guard_q <= '0;
         rdata_q <= 8'h00;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         guard_q <= guard_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      guard_d = guard_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;

      // Guard only ages while the processor actually owns the bus.
      if ((state_q == S_IDLE || state_q == S_ACCESS) && guard_q != '0) begin
         guard_d = guard_q - GW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (bus.hld && (guard_q == '0 || !bus.cpu_req)) begin
               state_d = S_FLOAT;
            end else if (bus.cpu_req) begin
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            ready_d = 1'b1;
            if (!bus.cpu_rw) begin
               rdata_d = databus;
            end
            state_d = S_IDLE;
         end
         S_FLOAT: begin
            state_d = bus.hld ? S_HOLD : S_IDLE;
         end
         S_HOLD: begin
            if (!bus.hld) begin
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
            guard_d = GW'(MIN_CPU_CYCLES);
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign drive_bus = (state_q == S_IDLE) || (state_q == S_ACCESS);
   assign in_access = (state_q == S_ACCESS);

   assign addressbus = drive_bus ? (in_access ? bus.cpu_addr : 8'h00) : 8'hzz;
   assign control    = drive_bus ? (in_access & bus.cpu_rw) : 1'bz;
   assign databus    = (in_access && bus.cpu_rw) ? bus.cpu_wdata : 8'hzz;

   assign bus.hlda      = (state_q == S_HOLD);
   assign bus.cpu_ready = ready_q;
   assign bus.cpu_rdata = rdata_q;

endmodule
